// File: rtl/memory_cycle_pkg.sv
// Shared encodings for the memory-access stage: funct3 sizes, FSM states,
// byte-enable bases and the size-alignment helper.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [7:0] BE_B = 8'h01;
  localparam logic [7:0] BE_H = 8'h03;
  localparam logic [7:0] BE_W = 8'h0F;
  localparam logic [7:0] BE_D = 8'hFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  // Offset bits that may legally be non-zero for a given access size.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      2'b00:   align_mask = 3'b111;
      2'b01:   align_mask = 3'b110;
      2'b10:   align_mask = 3'b100;
      default: align_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/memory_cycle_load_extend.sv
// Load formatter: selects the addressed byte lane of the read doubleword and
// sign- or zero-extends it to 64 bits according to funct3.
module load_extend
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  output logic [63:0] result
);

  logic [63:0] shifted;

  // Lane select followed by size-dependent extension.
  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (funct3)
      F3_B:    result = {{56{shifted[7]}},  shifted[7:0]};
      F3_H:    result = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    result = {{32{shifted[31]}}, shifted[31:0]};
      F3_D:    result = shifted;
      F3_BU:   result = {56'd0, shifted[7:0]};
      F3_HU:   result = {48'd0, shifted[15:0]};
      F3_WU:   result = {32'd0, shifted[31:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/memory_cycle.sv
// Memory-access stage: drives the req/gnt/rvalid data port, formats load
// data and holds the MEM/WB register. Optional feature macro:
// MEMORY_CYCLE_MISALIGN_TRAP_EN (misaligned accesses trap instead of being
// silently aligned).
module memory_cycle
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ValidM,
  input  logic        RegWriteM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [2:0]  Funct3M,
  input  logic [4:0]  RdM,
  input  logic [63:0] ALU_ResultM,
  input  logic [63:0] WriteDataM,
  input  logic [63:0] PCPlus4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [7:0]  dmem_be,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [63:0] dmem_rdata,
  output logic        StallM,
  output logic        ValidW,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RdW,
  output logic [63:0] ALU_ResultW,
  output logic [63:0] ReadDataW,
  output logic [63:0] PCPlus4W
`ifdef MEMORY_CYCLE_MISALIGN_TRAP_EN
  ,
  output logic        MisalignW
`endif
);

  state_t      state, state_next;
  logic        mem_op, is_load, req_state, misalign, trap, retire_mem, retire;
  logic [2:0]  off_raw, mask, off;
  logic [7:0]  be_base;
  logic [63:0] load_data;

  assign mem_op    = ValidM & (MemReadM | MemWriteM);
  assign is_load   = MemReadM & ~MemWriteM;
  assign off_raw   = ALU_ResultM[2:0];
  assign mask      = align_mask(Funct3M[1:0]);
  assign req_state = (state == IDLE) || (state == WAIT_GNT);
  assign dmem_addr = {ALU_ResultM[63:3], 3'b000};

`ifdef MEMORY_CYCLE_MISALIGN_TRAP_EN
  assign misalign = |(off_raw & ~mask);
  assign off      = off_raw;
`else
  assign misalign = 1'b0;
  assign off      = off_raw & mask;
`endif

  assign trap       = mem_op & req_state & misalign;
  assign retire_mem = (dmem_req & dmem_gnt & MemWriteM) | trap |
                      (mem_op & (state == WAIT_RSP) & dmem_rvalid);
  assign retire     = (ValidM & ~mem_op) | retire_mem;

  load_extend u_load_extend (
    .rdata  (dmem_rdata),
    .off    (off),
    .funct3 (Funct3M),
    .result (load_data)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: one outstanding transaction; stores finish on grant.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, WAIT_GNT: begin
        if (mem_op && !misalign) begin
          if (dmem_gnt) state_next = MemWriteM ? IDLE : WAIT_RSP;
          else          state_next = WAIT_GNT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT_RSP: if (dmem_rvalid) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Memory-port and stall outputs.
  always_comb begin
    case (Funct3M[1:0])
      2'b00:   be_base = BE_B;
      2'b01:   be_base = BE_H;
      2'b10:   be_base = BE_W;
      default: be_base = BE_D;
    endcase
    dmem_req   = mem_op & req_state & ~misalign;
    dmem_we    = MemWriteM;
    dmem_be    = be_base << off;
    dmem_wdata = WriteDataM << {off, 3'b000};
    StallM     = mem_op & ~retire_mem;
  end

  // MEM/WB register: capture on retire, otherwise insert a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ValidW      <= 1'b0;
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RdW         <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      PCPlus4W    <= '0;
`ifdef MEMORY_CYCLE_MISALIGN_TRAP_EN
      MisalignW   <= 1'b0;
`endif
    end else if (retire) begin
      ValidW      <= 1'b1;
      RegWriteW   <= RegWriteM & ~trap;
      ResultSrcW  <= ResultSrcM;
      RdW         <= RdM;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= (mem_op & is_load & ~trap) ? load_data : '0;
      PCPlus4W    <= PCPlus4M;
`ifdef MEMORY_CYCLE_MISALIGN_TRAP_EN
      MisalignW   <= trap;
`endif
    end else begin
      ValidW      <= 1'b0;
      RegWriteW   <= 1'b0;
`ifdef MEMORY_CYCLE_MISALIGN_TRAP_EN
      MisalignW   <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Scoreboard bench for memory_cycle: stimulus pushes expected MEM/WB records,
// a monitor pops and compares them whenever ValidW is presented.
module tb_memory_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidM, RegWriteM, MemReadM, MemWriteM, ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RdM;
  logic [63:0] ALU_ResultM, WriteDataM, PCPlus4M;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_be;
  logic        StallM, ValidW, RegWriteW, ResultSrcW;
  logic [4:0]  RdW;
  logic [63:0] ALU_ResultW, ReadDataW, PCPlus4W;
`ifdef MEMORY_CYCLE_MISALIGN_TRAP_EN
  logic        MisalignW;
`endif

  memory_cycle dut (
    .clk(clk), .rst(rst),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .MemReadM(MemReadM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
    .RdM(RdM), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .ValidW(ValidW), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .RdW(RdW), .ALU_ResultW(ALU_ResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W)
`ifdef MEMORY_CYCLE_MISALIGN_TRAP_EN
    , .MisalignW(MisalignW)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic        rs;
    logic [63:0] alu;
    logic [63:0] rdd;
    logic [63:0] pc4;
    logic        mis;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented MEM/WB result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && ValidW) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_retire: got ValidW=1 with ALU_ResultW=%h expected no retire", ALU_ResultW);
      end else begin
        e = q.pop_front();
        chk("w_rd", {59'd0, RdW}, {59'd0, e.rd});
        chk("w_regwrite", {63'd0, RegWriteW}, {63'd0, e.rw});
        chk("w_resultsrc", {63'd0, ResultSrcW}, {63'd0, e.rs});
        chk("w_alu", ALU_ResultW, e.alu);
        chk("w_readdata", ReadDataW, e.rdd);
        chk("w_pcplus4", PCPlus4W, e.pc4);
`ifdef MEMORY_CYCLE_MISALIGN_TRAP_EN
        chk("w_misalign", {63'd0, MisalignW}, {63'd0, e.mis});
`endif
      end
    end
  end

  task automatic set_m(input logic v, rw, mr, mw, rs, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [63:0] alu, wd, pc4);
    ValidM = v; RegWriteM = rw; MemReadM = mr; MemWriteM = mw; ResultSrcM = rs;
    Funct3M = f3; RdM = rd; ALU_ResultM = alu; WriteDataM = wd; PCPlus4M = pc4;
  endtask

  task automatic push(input logic [4:0] rd, input logic rw, rs,
                      input logic [63:0] alu, rdd, pc4, input logic mis);
    exp_t x;
    x.rd = rd; x.rw = rw; x.rs = rs; x.alu = alu; x.rdd = rdd; x.pc4 = pc4; x.mis = mis;
    q.push_back(x);
  endtask

  // One clock: drive memory response, check req/stall at negedge.
  task automatic cyc(input logic gnt, rv, input logic [63:0] rd,
                     input logic ereq, estall, input string tag);
    dmem_gnt = gnt; dmem_rvalid = rv; dmem_rdata = rd;
    @(negedge clk);
    chk({tag, "_req"}, {63'd0, dmem_req}, {63'd0, ereq});
    chk({tag, "_stall"}, {63'd0, StallM}, {63'd0, estall});
    @(posedge clk); #1;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
  endtask

  task automatic chk_w_zero(input string tag);
    chk({tag, "_validw"}, {63'd0, ValidW}, 64'd0);
    chk({tag, "_regwritew"}, {63'd0, RegWriteW}, 64'd0);
    chk({tag, "_rdw"}, {59'd0, RdW}, 64'd0);
    chk({tag, "_aluw"}, ALU_ResultW, 64'd0);
    chk({tag, "_readdataw"}, ReadDataW, 64'd0);
    chk({tag, "_pc4w"}, PCPlus4W, 64'd0);
`ifdef MEMORY_CYCLE_MISALIGN_TRAP_EN
    chk({tag, "_misalignw"}, {63'd0, MisalignW}, 64'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_m(0, 0, 0, 0, 0, 3'd0, 5'd0, 64'd0, 64'd0, 64'd0);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    @(negedge clk);
    chk_w_zero("reset");
    chk("reset_req", {63'd0, dmem_req}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ADD passthrough
    set_m(1, 1, 0, 0, 0, 3'd0, 5'd5, 64'h1234, 64'd0, 64'h104);
    push(5'd5, 1, 0, 64'h1234, 64'd0, 64'h104, 0);
    cyc(0, 0, 0, 0, 0, "add");

    // SB at 0x1003, immediate grant
    set_m(1, 0, 0, 1, 0, 3'b000, 5'd0, 64'h1003, 64'hAB, 64'h108);
    #1;
    chk("sb_addr", dmem_addr, 64'h1000);
    chk("sb_be", {56'd0, dmem_be}, 64'h08);
    chk("sb_wdata", dmem_wdata, 64'hAB00_0000);
    chk("sb_we", {63'd0, dmem_we}, 64'd1);
    push(5'd0, 0, 0, 64'h1003, 64'd0, 64'h108, 0);
    cyc(1, 0, 0, 1, 0, "sb");

    // LH at 0x2002, grant now, rvalid next
    set_m(1, 1, 1, 0, 1, 3'b001, 5'd7, 64'h2002, 64'd0, 64'h10C);
    #1;
    chk("lh_be", {56'd0, dmem_be}, 64'h0C);
    chk("lh_we", {63'd0, dmem_we}, 64'd0);
    cyc(1, 0, 0, 1, 1, "lh_gnt");
    push(5'd7, 1, 1, 64'h2002, 64'hFFFF_FFFF_FFFF_8001, 64'h10C, 0);
    cyc(0, 1, 64'h0000_0000_8001_0000, 0, 0, "lh_rsp");

    // LHU, same access
    set_m(1, 1, 1, 0, 1, 3'b101, 5'd8, 64'h2002, 64'd0, 64'h110);
    cyc(1, 0, 0, 1, 1, "lhu_gnt");
    push(5'd8, 1, 1, 64'h2002, 64'h8001, 64'h110, 0);
    cyc(0, 1, 64'h0000_0000_8001_0000, 0, 0, "lhu_rsp");

    // LD with grant delayed three cycles
    set_m(1, 1, 1, 0, 1, 3'b011, 5'd11, 64'h4000, 64'd0, 64'h114);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 1, "ld_wait");
      chk("ld_bubble", {63'd0, ValidW}, 64'd0);
    end
    cyc(1, 0, 0, 1, 1, "ld_gnt");
    chk("ld_bubble", {63'd0, ValidW}, 64'd0);
    push(5'd11, 1, 1, 64'h4000, 64'h0123_4567_89AB_CDEF, 64'h114, 0);
    cyc(0, 1, 64'h0123_4567_89AB_CDEF, 0, 0, "ld_rsp");

    // LB at byte 5, negative byte
    set_m(1, 1, 1, 0, 1, 3'b000, 5'd12, 64'h5005, 64'd0, 64'h118);
    cyc(1, 0, 0, 1, 1, "lb_gnt");
    push(5'd12, 1, 1, 64'h5005, 64'hFFFF_FFFF_FFFF_FF9A, 64'h118, 0);
    cyc(0, 1, 64'h0000_9A00_0000_0000, 0, 0, "lb_rsp");

    // SW at 0x6004 with one wait cycle
    set_m(1, 0, 0, 1, 0, 3'b010, 5'd0, 64'h6004, 64'h1122_3344, 64'h11C);
    #1;
    chk("sw_be", {56'd0, dmem_be}, 64'hF0);
    chk("sw_wdata", dmem_wdata, 64'h1122_3344_0000_0000);
    cyc(0, 0, 0, 1, 1, "sw_wait");
    push(5'd0, 0, 0, 64'h6004, 64'd0, 64'h11C, 0);
    cyc(1, 0, 0, 1, 0, "sw_gnt");

    // Load with funct3 111 gives zero data
    set_m(1, 1, 1, 0, 0, 3'b111, 5'd13, 64'h8000, 64'd0, 64'h120);
    cyc(1, 0, 0, 1, 1, "f7_gnt");
    push(5'd13, 1, 0, 64'h8000, 64'd0, 64'h120, 0);
    cyc(0, 1, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, "f7_rsp");

    // LW at 0x3002
`ifdef MEMORY_CYCLE_MISALIGN_TRAP_EN
    set_m(1, 1, 1, 0, 1, 3'b010, 5'd10, 64'h3002, 64'd0, 64'h124);
    push(5'd10, 0, 1, 64'h3002, 64'd0, 64'h124, 1);
    cyc(1, 0, 0, 0, 0, "lw_trap");
`else
    set_m(1, 1, 1, 0, 1, 3'b010, 5'd10, 64'h3002, 64'd0, 64'h124);
    #1;
    chk("lw_addr", dmem_addr, 64'h3000);
    chk("lw_be", {56'd0, dmem_be}, 64'h0F);
    cyc(1, 0, 0, 1, 1, "lw_gnt");
    push(5'd10, 1, 1, 64'h3002, 64'hFFFF_FFFF_8000_0001, 64'h124, 0);
    cyc(0, 1, 64'h1111_1111_8000_0001, 0, 0, "lw_rsp");
`endif

    // Reset while in WAIT_RSP, then stray rvalid
    set_m(1, 1, 1, 0, 0, 3'b010, 5'd9, 64'h7000, 64'd0, 64'h128);
    cyc(1, 0, 0, 1, 1, "rst_lw_gnt");
    #2;
    rst = 1'b1;
    #1;
    chk_w_zero("rst_mid");
    chk("rst_mid_req", {63'd0, dmem_req}, 64'd1);
    set_m(0, 0, 0, 0, 0, 3'd0, 5'd0, 64'd0, 64'd0, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, "stray_rvalid");
    @(negedge clk);
    chk_w_zero("after_stray");
    @(posedge clk); #1;

    // FSM must be back in IDLE: SD with immediate grant retires at once
    set_m(1, 0, 0, 1, 0, 3'b011, 5'd0, 64'h7008, 64'hCAFE_F00D_1234_5678, 64'h12C);
    #1;
    chk("sd_be", {56'd0, dmem_be}, 64'hFF);
    chk("sd_wdata", dmem_wdata, 64'hCAFE_F00D_1234_5678);
    push(5'd0, 0, 0, 64'h7008, 64'd0, 64'h12C, 0);
    cyc(1, 0, 0, 1, 0, "sd");

    set_m(0, 0, 0, 0, 0, 3'd0, 5'd0, 64'd0, 64'd0, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_cycle.md
# memory_cycle

Memory-access stage of the 64-bit pipelined RISC-V core, between execute and writeback. It takes the EX/MEM bundle and runs loads and stores over a req/gnt/rvalid data-memory port. It formats load data by byte lane with sign or zero extension, and holds the MEM/WB pipeline register that feeds the writeback stage (`ALU_ResultW`, `ReadDataW`, `PCPlus4W`, `ResultSrcW`). It stalls upstream while a memory transaction is outstanding.

## Interface
- No parameters; data width fixed at 64, register index width 5.
- `clk` in 1: the single clock; everything registers on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ValidM, RegWriteM, MemReadM, MemWriteM, ResultSrcM` in 1 each: EX/MEM controls.
- `Funct3M` in 3: access size/sign.
- `RdM` in 5: destination register.
- `ALU_ResultM` in 64: effective address, or result for non-memory instructions.
- `WriteDataM` in 64: store data, in the low bits.
- `PCPlus4M` in 64: PC+4.
- `dmem_req` out 1: request valid.
- `dmem_we` out 1: write enable.
- `dmem_addr` out 64: doubleword-aligned address, `{ALU_ResultM[63:3],3'b0}`.
- `dmem_be` out 8: byte enables.
- `dmem_wdata` out 64: lane-shifted store data.
- `dmem_gnt` in 1: request accepted.
- `dmem_rvalid` in 1: read data valid.
- `dmem_rdata` in 64: read data.
- `StallM` out 1: freezes the PC, IF/ID, ID/EX and EX/MEM registers.
- `ValidW, RegWriteW, ResultSrcW` out 1 each: MEM/WB controls.
- `RdW` out 5: MEM/WB destination register.
- `ALU_ResultW, ReadDataW, PCPlus4W` out 64 each: MEM/WB data.
- `MisalignW` out 1: only present with `MEMORY_CYCLE_MISALIGN_TRAP_EN`.

## Operation
- Mem op: `ValidM & (MemReadM | MemWriteM)`. If both read and write are set, the write wins.
- FSM states: IDLE, WAIT_GNT, WAIT_RSP.
  - IDLE, mem op, `dmem_gnt=1`:
    - store: retires this cycle, stay in IDLE;
    - load: go to WAIT_RSP.
  - IDLE, mem op, `dmem_gnt=0`: go to WAIT_GNT.
  - WAIT_GNT: same exits as IDLE on `dmem_gnt=1`.
  - WAIT_RSP, `dmem_rvalid=1`: load retires, go to IDLE.
- `dmem_req` is combinational: high when there is a mem op and the state is IDLE or WAIT_GNT. It is low in WAIT_RSP.
- `dmem_we`, `dmem_be`, `dmem_wdata` are valid whenever `dmem_req=1`.
- `StallM = mem op & ~retire_this_cycle`.
  - Upstream holds the EX/MEM inputs stable while `StallM=1`.
- Store lanes, with `off = ALU_ResultM[2:0]`:
  - `Funct3M` 000/001/010/011 = SB/SH/SW/SD, giving be `8'h01/03/0F/FF << off`;
  - wdata = WriteDataM shifted left by `off*8`.
- Load formatting, `Funct3M` 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU:
  - shift `dmem_rdata` right by `off*8`;
  - take the low 8/16/32/64 bits;
  - sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU).
  - Funct3 111 on a load: ReadDataW=0.
- MEM/WB register, written every cycle:
  - on retire: capture all M fields, plus the formatted load data (ReadDataW=0 for non-loads);
  - on stall or no valid instruction: bubble with ValidW=0, RegWriteW=0; data fields hold their previous values.
- Non-mem valid instruction: passes through in one cycle, never stalls.
- `dmem_gnt`/`dmem_rvalid` seen in an unexpected state (e.g. rvalid in IDLE) is ignored.
- Reset (async, any time, including mid-transaction):
  - FSM goes to IDLE;
  - every W output goes to 0 (MisalignW too);
  - a pending rdata is discarded.
  - Combinational outputs follow the inputs once reset is released.

## Timing
- Non-mem instruction: 1 cycle M→W.
- Store, zero-wait memory: 1 cycle, StallM=0.
- Each cycle without gnt adds one cycle.
- Load, gnt in the same cycle and rvalid the next: 2 cycles, StallM=1 for exactly the first.
- Load result appears at W the cycle after rvalid.
- At most one transaction outstanding.

## Configuration
- `MEMORY_CYCLE_MISALIGN_TRAP_EN` defined: a mem op whose address is not size-aligned (H: `off[0]`; W: `off[1:0]`; D: `off[2:0]`):
  - raises no `dmem_req`;
  - retires in 1 cycle with MisalignW=1, RegWriteW=0, ValidW=1.
- `MEMORY_CYCLE_MISALIGN_TRAP_EN` undefined:
  - the MisalignW port is absent;
  - the low offset bits below the access size are forced to zero (an aligned access is performed).

## Structure
- Package `mem_pkg` holds:
  - the funct3 load/store encodings;
  - the FSM state enum;
  - the byte-enable base constants (01/03/0F/FF).
- Sub-module `load_extend`: combinational lane select plus sign/zero extension (rdata, off, funct3 → 64-bit result). It is instantiated once.

## Test plan
- ADD passthrough: ALU_ResultM=0x1234, RegWriteM=1, RdM=5 → next cycle ALU_ResultW=0x1234, RdW=5, RegWriteW=1, StallM never high.
- SB at addr 0x1003, WriteDataM=0xAB, gnt immediate:
  - dmem_addr=0x1000, be=0x08, wdata[31:24]=0xAB, StallM=0;
  - next cycle ValidW=1, RegWriteW=0.
- LH at addr 0x2002, rdata=0x0000_0000_8001_0000:
  - gnt same cycle, rvalid next; StallM=1 for 1 cycle;
  - ReadDataW=0xFFFF_FFFF_FFFF_8001.
  - Same access with LHU → 0x8001.
- LD with gnt delayed 3 cycles:
  - dmem_req held 4 cycles, then 1 WAIT_RSP cycle;
  - StallM high for 4 cycles in total, W bubbles meanwhile;
  - ReadDataW=rdata.
- rst asserted in WAIT_RSP, then rvalid pulsed after release:
  - all W outputs 0, FSM IDLE, rvalid ignored.
- With the macro: LW at 0x3002 → no dmem_req, MisalignW=1, RegWriteW=0 next cycle.
- Without the macro: LW at 0x3002 → be=0x0F on addr 0x3000.
